sabana_drain: RTL and testbench
===============================

SABANA_DRAIN -- requirements
Module: sabana_drain

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of RAM words streamed per run.
REQ-002 SHALL have parameter ADDR_W, default 6, meaning RAM address width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 SHALL have parameter DATA_W, default 32, meaning RAM word and stream data width.
REQ-004 SHALL have ports as follows; there is one clock, and reset is asynchronous and active-low.
- clock  in  1  sole clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  one-cycle request to begin a drain run.
- finish  out  1  high after the last beat has been accepted.
- y_addr  out  ADDR_W  RAM read address.
- y_in  in  DATA_W  RAM read data; valid one cycle after y_addr.
- m_data  out  DATA_W  stream data.
- m_valid  out  1  stream data valid.
- m_ready  in  1  downstream accepts the beat when high together with m_valid.
- m_last  out  1  marks the beat for address DEPTH-1.

Function
REQ-005 SHALL implement states IDLE, STREAM and DONE.
REQ-006 Transitions:
- IDLE->STREAM when start is sampled high.
- STREAM->DONE on the handshake of the beat carrying m_last.
- DONE->STREAM when start is sampled high.
REQ-007 start SHALL be ignored in STREAM.
REQ-008 On entry to STREAM, the read address SHALL be 0; it SHALL increment by 1 per issued read, and no read SHALL be issued after address DEPTH-1.
REQ-009 A read SHALL be issued only while (buffer occupancy + reads in flight) < 2, so that backpressure never drops data.
REQ-010 Read data SHALL be captured into a 2-entry FIFO on the cycle after issue, tagged with last = (address == DEPTH-1).
REQ-011 Stream outputs SHALL follow these rules:
- m_valid = FIFO non-empty.
- m_data and m_last come from the FIFO head.
- While m_valid is high and m_ready is low, m_data and m_last SHALL be held stable.
REQ-012 A FIFO push and pop in the same cycle SHALL both take effect, with occupancy unchanged.
REQ-013 With m_ready held high, the first m_valid SHALL occur exactly 3 cycles after the cycle in which start is sampled, and throughput SHALL then be 1 beat per cycle.
REQ-014 Words SHALL be emitted in address order 0..DEPTH-1, exactly once each.
REQ-015 finish SHALL be high in DONE only, and low in IDLE and STREAM.
REQ-016 y_addr SHALL hold its last value when no read is issued.

Reset
REQ-017 Asserting reset SHALL immediately set:
- state to IDLE;
- the address to 0;
- the FIFO to empty, with no reads in flight;
- m_valid, m_last and finish to 0;
- m_data to 0.
REQ-018 Reset mid-run SHALL discard all buffered data; the next start SHALL stream from address 0.

Configuration
REQ-019 When macro SABANA_DRAIN_CHECKSUM_EN is defined, the block SHALL add output checksum [DATA_W] with this behaviour:
- it holds the modulo-2**DATA_W sum of all accepted beats of the current run;
- it is cleared on reset and on each run start;
- it is stable while finish is high.
REQ-020 When SABANA_DRAIN_CHECKSUM_EN is not defined, the checksum port and its logic SHALL be absent, and the block is otherwise unchanged.

Structure
REQ-021 Package sabana_drain_pkg SHALL hold state_t and the default DEPTH, ADDR_W and DATA_W constants.
REQ-022 The 2-entry buffer SHALL be sub-module sabana_drain_fifo, with push/pop/full/empty and a data-plus-last payload.

Verification
REQ-023 Continuous drain: RAM y[i]=3*i, m_ready=1, pulse start.
- m_valid rises 3 cycles later.
- 64 beats occur on consecutive cycles: 0, 3, ..., 189.
- m_last is high only on beat 64.
- finish is high the cycle after that beat.
REQ-024 Alternating m_ready (1,0,1,0...): 64 beats arrive in order, with no duplicates or gaps.
REQ-025 m_ready held low for 20 cycles after beat 10:
- y_addr stops at most 2 beyond the last accepted address;
- m_data stays stable;
- the stream resumes with beat 11.
REQ-026 reset driven low during beat 30:
- m_valid and finish go to 0 without waiting for a clock edge;
- a subsequent start yields a full 64-beat run from y[0].
REQ-027 start pulsed during STREAM has no effect; start pulsed in DONE drops finish and replays all 64 beats.
REQ-028 With SABANA_DRAIN_CHECKSUM_EN defined, y[i]=0xFFFFFFFF for all i: checksum = 0xFFFFFFC0 while finish is high.

Source files
------------

// File: rtl/sabana_drain_pkg.sv
// Shared types and default sizing for the sabana_drain RAM-to-stream drain block.
package sabana_drain_pkg;

  localparam int DEFAULT_DEPTH  = 64;
  localparam int DEFAULT_ADDR_W = 6;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic [1:0] occupancy(input logic full, input logic empty);
    return full ? 2'd2 : (empty ? 2'd0 : 2'd1);
  endfunction

endpackage

// File: rtl/sabana_drain_fifo.sv
// Two-entry skid buffer holding {last, data}; head is a register so the
// stream output stays stable while the consumer stalls.
module sabana_drain_fifo #(
  parameter int W = 33
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  logic [1:0]   count;
  logic [W-1:0] tail;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // A simultaneous push and pop keeps the occupancy and shifts the queue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sabana_drain.sv
// Streams DEPTH words from a one-cycle-latency RAM out as a valid/ready stream.
// Optional running checksum output enabled by macro SABANA_DRAIN_CHECKSUM_EN.
module sabana_drain
  import sabana_drain_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              finish,
  output logic [ADDR_W-1:0] y_addr,
  input  logic [DATA_W-1:0] y_in,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
`ifdef SABANA_DRAIN_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] last_addr;
  logic              all_issued;
  logic              in_flight;
  logic              flight_last;
  logic              issue;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W:0]   head;
  logic [2:0]        credit;

  assign m_valid = !fifo_empty;
  assign m_data  = head[DATA_W-1:0];
  assign m_last  = head[DATA_W];
  assign pop     = m_valid && m_ready;

  // The slot freed by this cycle's pop is reusable at once, which is what
  // keeps a full-rate stream going with only two buffer entries.
  always_comb begin
    credit = {1'b0, occupancy(fifo_full, fifo_empty)} + {2'b00, in_flight} - {2'b00, pop};
    issue  = (state == STREAM) && !all_issued && (credit < 3'd2);
  end

  assign y_addr = issue ? rd_addr : last_addr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rd_addr     <= '0;
      last_addr   <= '0;
      all_issued  <= 1'b0;
      in_flight   <= 1'b0;
      flight_last <= 1'b0;
      finish      <= 1'b0;
    end else begin
      in_flight   <= issue;
      flight_last <= issue && (rd_addr == LAST_ADDR);
      if (issue) begin
        last_addr <= rd_addr;
        rd_addr   <= rd_addr + 1'b1;
        if (rd_addr == LAST_ADDR) all_issued <= 1'b1;
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= STREAM;
            rd_addr    <= '0;
            all_issued <= 1'b0;
            finish     <= 1'b0;
          end
        end
        STREAM: begin
          if (pop && m_last) begin
            state  <= DONE;
            finish <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sabana_drain_fifo #(.W(DATA_W + 1)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_flight),
    .pop   (pop),
    .din   ({flight_last, y_in}),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef SABANA_DRAIN_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      checksum <= '0;
    end else if (start && (state != STREAM)) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + m_data;
    end
  end
`endif

endmodule

// File: tb/tb_sabana_drain.sv
// Self-checking bench for sabana_drain: table of drain runs with a RAM model
// and an in-order scoreboard, plus reset and checksum corner sequences.
module tb_sabana_drain;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              finish;
  logic [ADDR_W-1:0] y_addr;
  logic [DATA_W-1:0] y_in;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
`ifdef SABANA_DRAIN_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Synchronous-read RAM: data for y_addr appears one cycle later.
  always @(posedge clock) y_in <= mem[y_addr];

  sabana_drain dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .finish  (finish),
    .y_addr  (y_addr),
    .y_in    (y_in),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last)
`ifdef SABANA_DRAIN_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  // mode: 0 ready always, 1 alternating, 2 random, 3 stall 20 cycles after beat 10
  typedef struct {
    int unsigned mult;
    logic [31:0] off;
    bit          rnd;
    int          mode;
    int          exp_last_cyc;
    int          pulse_cyc;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Starts a run and scoreboards every accepted beat against the RAM contents
  // in address order; abort_beat >= 0 asserts reset while that beat is offered.
  task automatic run_drain(input vec_t v, input int abort_beat);
    int cyc, got, first_cyc, last_cyc, stall_left;
    bit stall_used, prev_hold;
    logic [31:0] prev_data, sum;
    logic prev_last;
    for (int i = 0; i < DEPTH; i++)
      mem[i] = v.rnd ? 32'($urandom) : 32'(v.mult * 32'(i)) + v.off;
    sum = 0; got = 0; first_cyc = -1; last_cyc = -1;
    stall_left = 0; stall_used = 0; prev_hold = 0;
    prev_data = 0; prev_last = 0;
    start = 1; m_ready = 1;
    step();
    start = 0;
    cyc = 1;
    while (got < DEPTH && cyc < 400) begin
      case (v.mode)
        0: m_ready = 1;
        1: m_ready = ((cyc % 2) == 1);
        2: m_ready = 1'($urandom_range(0, 1));
        default: begin
          if (got == 10 && !stall_used) begin
            stall_used = 1;
            stall_left = 20;
          end
          m_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
      endcase
      start = (cyc == v.pulse_cyc);
      @(negedge clock);
      if (cyc == 1) check("finish_drop", {31'd0, finish}, 0);
      if (m_valid && first_cyc < 0) first_cyc = cyc;
      if (prev_hold) begin
        check("hold_valid", {31'd0, m_valid}, 1);
        check("hold_data", m_data, prev_data);
        check("hold_last", {31'd0, m_last}, {31'd0, prev_last});
      end
      if (v.mode == 3 && stall_used && !m_ready)
        check("stall_addr", {31'd0, (int'(y_addr) <= got + 1)}, 1);
      if (abort_beat >= 0 && m_valid && got == abort_beat) begin
        reset = 0;
        #1;
        check("abort_valid", {31'd0, m_valid}, 0);
        check("abort_finish", {31'd0, finish}, 0);
        check("abort_last", {31'd0, m_last}, 0);
        check("abort_data", m_data, 0);
        check("abort_addr", {26'd0, y_addr}, 0);
        start = 0;
        m_ready = 1;
        return;
      end
      if (m_valid && m_ready) begin
        check("beat_data", m_data, mem[got]);
        check("beat_last", {31'd0, m_last}, {31'd0, (got == DEPTH - 1)});
        sum += m_data;
        got++;
        if (got == DEPTH) last_cyc = cyc;
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      step();
      cyc++;
    end
    start = 0;
    m_ready = 1;
    check("beat_count", got, DEPTH);
    check("first_valid", first_cyc, 3);
    if (v.exp_last_cyc >= 0) check("last_beat_cycle", last_cyc, v.exp_last_cyc);
    if (got == DEPTH) begin
      @(negedge clock);
      check("finish_high", {31'd0, finish}, 1);
      check("valid_after", {31'd0, m_valid}, 0);
`ifdef SABANA_DRAIN_CHECKSUM_EN
      check("checksum", checksum, sum);
`endif
      step();
      @(negedge clock);
      check("finish_stays", {31'd0, finish}, 1);
`ifdef SABANA_DRAIN_CHECKSUM_EN
      check("checksum_stable", checksum, sum);
`endif
      step();
    end
  endtask

  initial begin
    vecs[0] = '{mult: 3, off: 32'd0,          rnd: 0, mode: 0, exp_last_cyc: 66, pulse_cyc: -1};
    vecs[1] = '{mult: 1, off: 32'd100,        rnd: 0, mode: 1, exp_last_cyc: -1, pulse_cyc: -1};
    vecs[2] = '{mult: 7, off: 32'd5,          rnd: 0, mode: 3, exp_last_cyc: -1, pulse_cyc: -1};
    vecs[3] = '{mult: 0, off: 32'd0,          rnd: 1, mode: 2, exp_last_cyc: -1, pulse_cyc: -1};
    vecs[4] = '{mult: 2, off: 32'd1,          rnd: 0, mode: 0, exp_last_cyc: 66, pulse_cyc: 20};
    vecs[5] = '{mult: 0, off: 32'hFFFF_FFFF,  rnd: 0, mode: 0, exp_last_cyc: 66, pulse_cyc: -1};

    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    reset = 1; start = 0; m_ready = 0;
    #2 reset = 0;
    #1;
    check("rst_valid", {31'd0, m_valid}, 0);
    check("rst_finish", {31'd0, finish}, 0);
    check("rst_last", {31'd0, m_last}, 0);
    check("rst_data", m_data, 0);
    check("rst_addr", {26'd0, y_addr}, 0);
    step();
    step();
    reset = 1;
    step();

    for (int i = 0; i < 6; i++) begin
      $display("[TB] run %0d mode %0d", i, vecs[i].mode);
      run_drain(vecs[i], -1);
    end
`ifdef SABANA_DRAIN_CHECKSUM_EN
    check("checksum_all_ones", checksum, 32'hFFFF_FFC0);
`endif

    // Reset while DONE: finish must drop without a clock edge.
    @(negedge clock);
    check("done_finish", {31'd0, finish}, 1);
    reset = 0;
    #1;
    check("done_reset_finish", {31'd0, finish}, 0);
    step();
    reset = 1;
    step();

    // Reset in the middle of beat 30, then a clean full run from address 0.
    run_drain(vecs[0], 29);
    step();
    step();
    reset = 1;
    step();
    run_drain(vecs[0], -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
